// File: rtl/mul_ctrl.sv
// Two-phase-load controller and 64-step shift-add engine for a 64x64 unsigned multiply.
// The A operand is latched on the first start edge and the B operand on the second; the product appears 64 cycles later.
module mul_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_opstart,
    input  logic        in_opclear,
    input  logic        in_intrEn,
    input  logic [63:0] in_operand,
    output logic [1:0]  out_opdone,
    output logic [63:0] out_result_h,
    output logic [63:0] out_result_l,
    output logic        out_intr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_B = 2'd1,
        EXEC   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t         r_state;
    logic           r_startD;
    logic [63:0]    r_a;
    logic [127:0]   r_p;
    logic [5:0]     r_cnt;
    logic           r_done;
    logic           r_busy;
    logic [63:0]    r_resH;
    logic [63:0]    r_resL;

    logic           w_edge;
    logic [63:0]    w_addend;
    logic [64:0]    w_sum;
    logic [127:0]   w_pNext;

    // Only a rising start level acts; a level held high never re-triggers.
    assign w_edge   = in_opstart & ~r_startD;

    // The sum is 65 bits wide so that its carry shifts into P[127].
    assign w_addend = r_p[0] ? r_a : 64'h0;
    assign w_sum    = {1'b0, r_p[127:64]} + {1'b0, w_addend};
    assign w_pNext  = {w_sum, r_p[63:1]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_startD <= 1'b0;
            r_a      <= 64'h0;
            r_p      <= 128'h0;
            r_cnt    <= 6'd0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_resH   <= 64'h0;
            r_resL   <= 64'h0;
        end else begin
            r_startD <= in_opstart;
            if (in_opclear) begin
                r_state <= IDLE;
                r_a     <= 64'h0;
                r_p     <= 128'h0;
                r_cnt   <= 6'd0;
                r_done  <= 1'b0;
                r_busy  <= 1'b0;
                r_resH  <= 64'h0;
                r_resL  <= 64'h0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_edge) begin
                            r_a     <= in_operand;
                            r_busy  <= 1'b1;
                            r_state <= WAIT_B;
                        end
                    end
                    WAIT_B: begin
                        if (w_edge) begin
                            r_p     <= {64'h0, in_operand};
                            r_cnt   <= 6'd0;
                            r_state <= EXEC;
                        end
                    end
                    // Start edges arriving here are dropped, not queued.
                    EXEC: begin
                        r_p   <= w_pNext;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == 6'd63) begin
                            r_resH  <= w_pNext[127:64];
                            r_resL  <= w_pNext[63:0];
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= DONE;
                        end
                    end
                    // Old results remain visible until the next run completes.
                    DONE: begin
                        if (w_edge) begin
                            r_a     <= in_operand;
                            r_done  <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= WAIT_B;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign out_opdone   = {r_busy, r_done};
    assign out_result_h = r_resH;
    assign out_result_l = r_resL;
    assign out_intr     = r_done & in_intrEn;

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl: inputs change on the falling edge, outputs are sampled there too.
module tb_mul_ctrl;

    logic        clk;
    logic        reset_n;
    logic        in_opstart;
    logic        in_opclear;
    logic        in_intrEn;
    logic [63:0] in_operand;
    logic [1:0]  out_opdone;
    logic [63:0] out_result_h;
    logic [63:0] out_result_l;
    logic        out_intr;

    int errors;
    int checks;
    int cycles;
    bit busyOk;

    mul_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_opstart   (in_opstart),
        .in_opclear   (in_opclear),
        .in_intrEn    (in_intrEn),
        .in_operand   (in_operand),
        .out_opdone   (out_opdone),
        .out_result_h (out_result_h),
        .out_result_l (out_result_l),
        .out_intr     (out_intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Produces one start edge carrying op; returns at the falling edge just after it.
    task automatic applyStimulus(input logic [63:0] op);
        @(negedge clk);
        in_operand = op;
        in_opstart = 1'b1;
        @(negedge clk);
        in_opstart = 1'b0;
    endtask

    // Counts falling edges until done, noting whether busy-only was shown all along.
    task automatic waitDone();
        cycles = 0;
        busyOk = 1'b1;
        while (out_opdone[0] !== 1'b1 && cycles < 200) begin
            if (out_opdone !== 2'b10) busyOk = 1'b0;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic pulseReset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        reset_n    = 1'b0;
        in_opstart = 1'b0;
        in_opclear = 1'b0;
        in_intrEn  = 1'b0;
        in_operand = 64'h0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        checkOutput("reset_opdone", out_opdone, 2'b00);
        checkOutput("reset_res_h", out_result_h, 64'h0);
        checkOutput("reset_res_l", out_result_l, 64'h0);
        checkOutput("reset_intr", out_intr, 1'b0);

        // 3 x 5
        applyStimulus(64'd3);
        checkOutput("basic_phase1_busy", out_opdone, 2'b10);
        applyStimulus(64'd5);
        waitDone();
        checkOutput("basic_latency", cycles, 64);
        checkOutput("basic_busy_held", busyOk, 1'b1);
        checkOutput("basic_opdone", out_opdone, 2'b01);
        checkOutput("basic_res_h", out_result_h, 64'h0);
        checkOutput("basic_res_l", out_result_l, 64'd15);

        // all-ones x all-ones
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("max_restart_opdone", out_opdone, 2'b10);
        checkOutput("max_old_res_l", out_result_l, 64'd15);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF);
        waitDone();
        checkOutput("max_latency", cycles, 64);
        checkOutput("max_res_h", out_result_h, 64'hFFFF_FFFF_FFFF_FFFE);
        checkOutput("max_res_l", out_result_l, 64'h0000_0000_0000_0001);

        // abort 7 x 9 mid-run, then 2 x 4
        applyStimulus(64'd7);
        applyStimulus(64'd9);
        repeat (29) @(negedge clk);
        in_opclear = 1'b1;
        @(negedge clk);
        in_opclear = 1'b0;
        checkOutput("abort_opdone", out_opdone, 2'b00);
        checkOutput("abort_res_h", out_result_h, 64'h0);
        checkOutput("abort_res_l", out_result_l, 64'h0);
        repeat (3) @(negedge clk);
        checkOutput("abort_stays_idle", out_opdone, 2'b00);
        applyStimulus(64'd2);
        checkOutput("abort_new_phase1", out_opdone, 2'b10);
        applyStimulus(64'd4);
        waitDone();
        checkOutput("abort_new_latency", cycles, 64);
        checkOutput("abort_new_res_l", out_result_l, 64'd8);

        // 10 x 10 with two stray start edges during EXEC
        applyStimulus(64'd10);
        applyStimulus(64'd10);
        repeat (10) @(negedge clk);
        applyStimulus(64'd99);
        repeat (10) @(negedge clk);
        applyStimulus(64'd99);
        waitDone();
        checkOutput("ignored_latency", cycles + 24, 64);
        checkOutput("ignored_res_l", out_result_l, 64'd100);
        checkOutput("ignored_opdone", out_opdone, 2'b01);
        repeat (4) @(negedge clk);
        checkOutput("ignored_still_done", out_opdone, 2'b01);

        // interrupt gating with 6 x 7
        applyStimulus(64'd6);
        applyStimulus(64'd7);
        waitDone();
        checkOutput("intr_res_l", out_result_l, 64'd42);
        checkOutput("intr_off", out_intr, 1'b0);
        checkOutput("intr_done_bit", out_opdone[0], 1'b1);
        in_intrEn = 1'b1;
        #1;
        checkOutput("intr_raise", out_intr, 1'b1);
        checkOutput("intr_done_unchanged", out_opdone, 2'b01);
        in_intrEn = 1'b0;
        #1;
        checkOutput("intr_drop", out_intr, 1'b0);
        in_intrEn = 1'b1;
        applyStimulus(64'd5);
        checkOutput("intr_restart_opdone", out_opdone, 2'b10);
        checkOutput("intr_restart_intr", out_intr, 1'b0);
        checkOutput("intr_restart_old_res", out_result_l, 64'd42);
        applyStimulus(64'd5);
        waitDone();
        checkOutput("intr_second_res_l", out_result_l, 64'd25);
        checkOutput("intr_second_intr", out_intr, 1'b1);

        // reset in WAIT_B, then in EXEC
        applyStimulus(64'd3);
        checkOutput("rst_waitb_busy", out_opdone, 2'b10);
        pulseReset();
        checkOutput("rst_waitb_opdone", out_opdone, 2'b00);
        checkOutput("rst_waitb_res_l", out_result_l, 64'h0);
        checkOutput("rst_waitb_intr", out_intr, 1'b0);
        applyStimulus(64'd4);
        applyStimulus(64'd6);
        repeat (10) @(negedge clk);
        pulseReset();
        checkOutput("rst_exec_opdone", out_opdone, 2'b00);
        checkOutput("rst_exec_res_h", out_result_h, 64'h0);
        checkOutput("rst_exec_res_l", out_result_l, 64'h0);
        applyStimulus(64'd11);
        checkOutput("rst_phase1_busy", out_opdone, 2'b10);
        applyStimulus(64'd12);
        waitDone();
        checkOutput("rst_after_latency", cycles, 64);
        checkOutput("rst_after_res_l", out_result_l, 64'd132);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
